// File: rtl/sha1_wb_agent.sv
// rtl/sha1_wb_agent.sv - SHA-1 result write-back agent: push FIFO drained to memory over req/ack.
// Counts committed words and pulses done_o once per WORDS-word digest.
module sha1_wb_agent #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 8,
  parameter int WORDS = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid_i,
  input  logic [DW-1:0]            wr_data_i,
  input  logic [AW-1:0]            wr_addr_i,
  input  logic                     clr_i,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [AW-1:0]            mem_addr_o,
  output logic [DW-1:0]            mem_wdata_o,
  input  logic                     mem_ack_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(WORDS + 1);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_fifo_addr [DEPTH];
  logic [DW-1:0]   r_fifo_data [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]   r_level, w_level_nxt;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            r_busy, r_done, r_ovf;
  logic            w_load, w_pop, w_push, w_drop, w_full, w_cnt_hit;

  assign w_full    = (r_level == LW'(DEPTH));
  assign w_push    = wr_valid_i & ~clr_i & (~w_full | w_pop);
  assign w_drop    = wr_valid_i & ~clr_i & w_full & ~w_pop;
  assign w_cnt_hit = w_pop & (r_cnt == CW'(WORDS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_level != '0) begin
          w_state_nxt = S_REQ;
          w_load      = 1'b1;
        end
      end
      S_REQ: begin
        if (mem_ack_i) begin
          w_pop       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Clear abandons any outstanding request, so a same-edge ack is not a pop.
    if (clr_i) begin
      w_state_nxt = S_IDLE;
      w_load      = 1'b0;
      w_pop       = 1'b0;
    end
  end

  always_comb begin
    w_level_nxt = r_level;
    if (clr_i)
      w_level_nxt = '0;
    else if (w_push && !w_pop)
      w_level_nxt = r_level + LW'(1);
    else if (w_pop && !w_push)
      w_level_nxt = r_level - LW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      r_busy  <= (w_level_nxt != '0) | (w_state_nxt == S_REQ);
      r_done  <= w_cnt_hit;
      if (clr_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
        r_ovf    <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        if (w_drop) r_ovf    <= 1'b1;
        if (w_cnt_hit)
          r_cnt <= '0;
        else if (w_pop)
          r_cnt <= r_cnt + CW'(1);
      end
      if (w_load) begin
        r_addr  <= r_fifo_addr[r_rd_ptr];
        r_wdata <= r_fifo_data[r_rd_ptr];
      end
    end
  end

  // Head is copied into r_addr/r_wdata at load, so a full-FIFO push may reuse the popped slot.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= wr_addr_i;
      r_fifo_data[r_wr_ptr] <= wr_data_i;
    end
  end

  assign mem_req_o   = (r_state == S_REQ);
  assign mem_we_o    = mem_req_o;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign overflow_o  = r_ovf;
  assign level_o     = r_level;
endmodule

// File: tb/tb_sha1_wb_agent.sv
// tb/tb_sha1_wb_agent.sv - self-checking bench for sha1_wb_agent against a queue-based model.
module tb_sha1_wb_agent;
  localparam int DEPTH = 8;
  localparam int WORDS = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid_i = 1'b0;
  logic [31:0] wr_data_i = '0;
  logic [31:0] wr_addr_i = '0;
  logic        clr_i = 1'b0;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic        busy_o, done_o, overflow_o;
  logic [3:0]  level_o;

  sha1_wb_agent #(.DW(32), .AW(32), .DEPTH(DEPTH), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i),
    .wr_addr_i(wr_addr_i), .clr_i(clr_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
    .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o), .level_o(level_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  int          m_cnt = 0;
  bit          m_ovf = 0;
  bit          m_done = 0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_writes = 0;
  int          n_dones = 0;
  int          peak = 0;
  int          wr_cycles[$];
  logic [31:0] last_wdata = '0;

  task automatic tick(input bit v, input logic [31:0] a, input logic [31:0] d,
                      input bit ack, input bit clr);
    bit req_b, pop, exp_req;
    logic [31:0] addr_b, data_b;
    int sz_b;
    ent_t e;
    wr_valid_i = v; wr_addr_i = a; wr_data_i = d; mem_ack_i = ack; clr_i = clr;
    @(negedge clk);
    req_b = mem_req_o; addr_b = mem_addr_o; data_b = mem_wdata_o; sz_b = mq.size();
    @(posedge clk);
    #1;
    cyc++;
    pop = req_b && ack && !clr;
    m_done = 0;
    if (clr) begin
      mq.delete(); m_cnt = 0; m_ovf = 0;
    end else begin
      if (pop) begin
        checks++;
        if (mq.size() == 0) begin
          errors++; $display("FAIL write_unexpected: got addr %h data %h, required no write", addr_b, data_b);
        end else begin
          if (addr_b !== mq[0].a || data_b !== mq[0].d) begin
            errors++;
            $display("FAIL write_order: got %h/%h required %h/%h", addr_b, data_b, mq[0].a, mq[0].d);
          end
          void'(mq.pop_front());
        end
        n_writes++; last_wdata = data_b; wr_cycles.push_back(cyc);
        m_cnt++;
        if (m_cnt == WORDS) begin m_cnt = 0; m_done = 1; end
      end
      if (v) begin
        if (mq.size() < DEPTH) begin e.a = a; e.d = d; mq.push_back(e); end
        else m_ovf = 1;
      end
    end
    exp_req = clr ? 1'b0 : (req_b ? !ack : (sz_b > 0));
    checks += 6;
    if (level_o !== 4'(mq.size())) begin errors++; $display("FAIL level: got %0d required %0d", level_o, mq.size()); end
    if (overflow_o !== m_ovf) begin errors++; $display("FAIL overflow: got %b required %b", overflow_o, m_ovf); end
    if (done_o !== m_done) begin errors++; $display("FAIL done: got %b required %b", done_o, m_done); end
    if (busy_o !== (mq.size() > 0)) begin errors++; $display("FAIL busy: got %b required %b", busy_o, mq.size() > 0); end
    if (mem_req_o !== exp_req) begin errors++; $display("FAIL req: got %b required %b", mem_req_o, exp_req); end
    if (mem_we_o !== mem_req_o) begin errors++; $display("FAIL we: got %b required %b", mem_we_o, mem_req_o); end
    if (req_b && !ack && !clr) begin
      checks++;
      if (mem_addr_o !== addr_b || mem_wdata_o !== data_b) begin
        errors++; $display("FAIL hold: got %h/%h required %h/%h", mem_addr_o, mem_wdata_o, addr_b, data_b);
      end
    end
    if (done_o === 1'b1) n_dones++;
    if (int'(level_o) > peak) peak = int'(level_o);
  endtask

  task automatic push_words(input int n, input logic [31:0] a0, input logic [31:0] d0, input bit ack);
    for (int i = 0; i < n; i++) tick(1'b1, a0 + 32'(4 * i), d0 + 32'(i), ack, 1'b0);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((mq.size() != 0 || mem_req_o === 1'b1) && k < budget) begin
      tick(1'b0, '0, '0, 1'b1, 1'b0);
      k++;
    end
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (mq.size() != 0 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL drain_timeout: got level %0d req %b, required empty", level_o, mem_req_o);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o, overflow_o, level_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: got req %b addr %h data %h level %0d, required all 0", mem_req_o, mem_addr_o, mem_wdata_o, level_o);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (level_o !== 4'd0 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL reset_release: got level %0d req %b, required 0 0", level_o, mem_req_o);
    end
  endtask

  task automatic test_basic_digest;
    int w0;
    peak = 0; n_dones = 0; w0 = n_writes; wr_cycles.delete();
    push_words(5, 32'h100, 32'h67452301, 1'b1);
    drain(40);
    checks += 3;
    if (n_writes - w0 != 5) begin errors++; $display("FAIL basic_writes: got %0d required 5", n_writes - w0); end
    if (n_dones != 1) begin errors++; $display("FAIL basic_done: got %0d required 1", n_dones); end
    if (peak != 3) begin errors++; $display("FAIL basic_peak: got %0d required 3", peak); end
    for (int i = 1; i < wr_cycles.size(); i++) begin
      checks++;
      if (wr_cycles[i] - wr_cycles[i-1] != 2) begin
        errors++; $display("FAIL basic_spacing: got %0d required 2", wr_cycles[i] - wr_cycles[i-1]);
      end
    end
  endtask

  task automatic test_backpressure;
    int w0;
    w0 = n_writes;
    push_words(5, 32'h100, 32'hA5A50000, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, '0, '0, 1'b0, 1'b0);
    checks += 4;
    if (mem_req_o !== 1'b1) begin errors++; $display("FAIL bp_req: got %b required 1", mem_req_o); end
    if (mem_addr_o !== 32'h100 || mem_wdata_o !== 32'hA5A50000) begin
      errors++; $display("FAIL bp_head: got %h/%h required 00000100/a5a50000", mem_addr_o, mem_wdata_o);
    end
    if (level_o !== 4'd5) begin errors++; $display("FAIL bp_level: got %0d required 5", level_o); end
    if (busy_o !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b required 1", busy_o); end
    drain(40);
    checks++;
    if (n_writes - w0 != 5) begin errors++; $display("FAIL bp_writes: got %0d required 5", n_writes - w0); end
  endtask

  task automatic test_overflow;
    int w0;
    tick(1'b0, '0, '0, 1'b0, 1'b1);
    w0 = n_writes;
    for (int i = 0; i < 9; i++) tick(1'b1, 32'h200 + 32'(4 * i), $urandom, 1'b0, 1'b0);
    checks += 2;
    if (level_o !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d required 8", level_o); end
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b required 1", overflow_o); end
    drain(40);
    checks += 2;
    if (n_writes - w0 != 8) begin errors++; $display("FAIL ovf_writes: got %0d required 8", n_writes - w0); end
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", overflow_o); end
    tick(1'b0, '0, '0, 1'b0, 1'b1);
    checks++;
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b required 0", overflow_o); end
  endtask

  task automatic test_full_push_pop;
    for (int i = 0; i < 8; i++) tick(1'b1, 32'h300 + 32'(4 * i), $urandom, 1'b0, 1'b0);
    tick(1'b1, 32'h3F0, 32'hDEADBEEF, 1'b1, 1'b0);
    checks += 2;
    if (level_o !== 4'd8) begin errors++; $display("FAIL fpp_level: got %0d required 8", level_o); end
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b required 0", overflow_o); end
    drain(60);
    checks++;
    if (last_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fpp_last: got %h required deadbeef", last_wdata); end
  endtask

  task automatic test_clear_mid;
    tick(1'b0, '0, '0, 1'b0, 1'b1);
    push_words(2, 32'h400, 32'h11110000, 1'b1);
    drain(20);
    push_words(3, 32'h500, 32'h22220000, 1'b0);
    tick(1'b0, '0, '0, 1'b0, 1'b0);
    tick(1'b1, 32'h5F0, 32'h33333333, 1'b1, 1'b1);
    checks += 2;
    if (mem_req_o !== 1'b0) begin errors++; $display("FAIL clr_req: got %b required 0", mem_req_o); end
    if (level_o !== 4'd0) begin errors++; $display("FAIL clr_level: got %0d required 0", level_o); end
    n_dones = 0;
    push_words(5, 32'h600, 32'h44440000, 1'b1);
    drain(40);
    checks++;
    if (n_dones != 1) begin errors++; $display("FAIL clr_digest_done: got %0d required 1", n_dones); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 2000; i++)
      tick($urandom_range(0, 9) < 6, $urandom, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) == 0);
    drain(60);
  endtask

  task automatic test_async_reset;
    tick(1'b0, '0, '0, 1'b0, 1'b1);
    tick(1'b1, 32'h700, 32'h55555555, 1'b0, 1'b0);
    tick(1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (mem_req_o !== 1'b1) begin errors++; $display("FAIL ar_setup_req: got %b required 1", mem_req_o); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o, overflow_o, level_o} !== '0) begin
      errors++; $display("FAIL ar_outputs: got req %b addr %h data %h level %0d, required all 0", mem_req_o, mem_addr_o, mem_wdata_o, level_o);
    end
    mq.delete(); m_cnt = 0; m_ovf = 0; m_done = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_dones = 0;
    push_words(5, 32'h800, 32'h66660000, 1'b1);
    drain(40);
    checks++;
    if (n_dones != 1) begin errors++; $display("FAIL ar_resume_done: got %0d required 1", n_dones); end
  endtask

  initial begin
    test_reset;
    test_basic_digest;
    test_backpressure;
    test_overflow;
    test_full_push_pop;
    test_clear_mid;
    test_random;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end
endmodule
